// File: rtl/tag_array_nway.sv
// rtl/tag_array_nway.sv - N-way set-associative tag store with valid bits, tree-PLRU and clear sweep (optional TAG_ARRAY_BYPASS_EN)
module tag_array_nway #(
  parameter int TAG_W = 20,
  parameter int IDX_W = 7,
  parameter int WAYS  = 4,
  localparam int WW   = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lk_valid_i,
  input  logic [IDX_W-1:0] lk_index_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             ready_o,
  output logic             rsp_valid_o,
  output logic             rsp_hit_o,
  output logic [WAYS-1:0]  rsp_way_o,
  output logic [WW-1:0]    rsp_victim_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [WW-1:0]    wr_way_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             inv_en_i,
  input  logic [IDX_W-1:0] inv_index_i,
  input  logic [WW-1:0]    inv_way_i,
  input  logic             flush_req_i
);
  localparam int SETS = 2 ** IDX_W;
  localparam int PW   = WAYS - 1;

  typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   sweep_idx_q;
  logic               ready_q;

  logic [WAYS-1:0][TAG_W-1:0] tag_mem [SETS];
  logic [WAYS-1:0]            valid_q [SETS];
  logic [PW-1:0]              plru_q  [SETS];

  logic                       lk_pend_q;
  logic [IDX_W-1:0]           lk_idx_q;
  logic [TAG_W-1:0]           lk_tag_q;
  logic [WAYS-1:0][TAG_W-1:0] tag_row_q;
  logic [WAYS-1:0]            vrow_q;
  logic [PW-1:0]              prow_q;
  logic [WAYS-1:0]            vrow_d;
  logic [WAYS-1:0][TAG_W-1:0] tag_row_eff;

  logic            hit_q;
  logic [WAYS-1:0] way_q;
  logic [WW-1:0]   vict_q;

  logic            lk_acc, wr_acc, inv_acc;
  logic [WAYS-1:0] match_c;
  logic            hit_c;
  logic [WW-1:0]   hit_way_c;
  logic [WW-1:0]   vict_c;
  logic            hit_upd;
  logic [PW-1:0]   plru_hit_new;
  logic [PW-1:0]   plru_wr_base;

`ifdef TAG_ARRAY_BYPASS_EN
  logic            byp_q;
  logic [WW-1:0]   byp_way_q;
  logic [TAG_W-1:0] byp_tag_q;
`endif

  // Tree nodes are heap-ordered (root 0, children 2n+1/2n+2); a 1 points the LRU search right.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t_in, input logic [WW-1:0] w);
    logic [PW-1:0] t;
    int n;
    int p;
    t = t_in;
    n = int'(w) + WAYS - 1;
    for (int l = 0; l < WW; l++) begin
      p    = (n - 1) / 2;
      t[p] = n[0];
      n    = p;
    end
    return t;
  endfunction

  function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] t);
    int n;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      n = 2 * n + 1 + int'(t[n]);
    end
    return WW'(n - (WAYS - 1));
  endfunction

  assign lk_acc  = lk_valid_i & ready_q;
  assign wr_acc  = wr_en_i & ready_q;
  assign inv_acc = inv_en_i & ready_q;
  assign ready_o = ready_q;

  // Sweep/idle control: reset or flush restarts the clear sweep at set 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (&sweep_idx_q) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          if (flush_req_i) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
            ready_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Tag RAM: one write port, one registered read port (read-before-write on collision)
  always_ff @(posedge clk_i) begin
    if (wr_acc) tag_mem[wr_index_i][wr_way_i] <= wr_tag_i;
    if (lk_acc) tag_row_q <= tag_mem[lk_index_i];
  end

  // Valid row seen by an accepted lookup, optionally forwarding same-cycle write/invalidate
  always_comb begin
    vrow_d = valid_q[lk_index_i];
`ifdef TAG_ARRAY_BYPASS_EN
    if (inv_acc && inv_index_i == lk_index_i) vrow_d[inv_way_i] = 1'b0;
    if (wr_acc && wr_index_i == lk_index_i) vrow_d[wr_way_i] = 1'b1;
`endif
  end

  // Lookup capture stage: snapshot valid/PLRU state alongside the RAM read
  always_ff @(posedge clk_i) begin
    if (rst_i) lk_pend_q <= 1'b0;
    else       lk_pend_q <= lk_acc;
    if (lk_acc) begin
      lk_idx_q <= lk_index_i;
      lk_tag_q <= lk_tag_i;
      vrow_q   <= vrow_d;
      prow_q   <= plru_q[lk_index_i];
`ifdef TAG_ARRAY_BYPASS_EN
      byp_q     <= wr_acc && (wr_index_i == lk_index_i);
      byp_way_q <= wr_way_i;
      byp_tag_q <= wr_tag_i;
`endif
    end
  end

  // Compare, hit encode and victim choice on the captured row
  always_comb begin
    tag_row_eff = tag_row_q;
`ifdef TAG_ARRAY_BYPASS_EN
    if (byp_q) tag_row_eff[byp_way_q] = byp_tag_q;
`endif
    hit_way_c = '0;
    vict_c    = plru_victim(prow_q);
    for (int i = 0; i < WAYS; i++) begin
      match_c[i] = vrow_q[i] && (tag_row_eff[i] == lk_tag_q);
      if (match_c[i]) hit_way_c = WW'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vrow_q[i]) vict_c = WW'(i);
    end
    hit_c = |match_c;
  end

  // Hold the last response while no new result is presented
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q  <= 1'b0;
      way_q  <= '0;
      vict_q <= '0;
    end else if (lk_pend_q) begin
      hit_q  <= hit_c;
      way_q  <= match_c;
      vict_q <= vict_c;
    end
  end

  assign rsp_valid_o  = lk_pend_q;
  assign rsp_hit_o    = lk_pend_q ? hit_c   : hit_q;
  assign rsp_way_o    = lk_pend_q ? match_c : way_q;
  assign rsp_victim_o = lk_pend_q ? vict_c  : vict_q;

  // Hit touch is applied before a same-set write so the written way ends up MRU
  assign hit_upd      = lk_pend_q & hit_c;
  assign plru_hit_new = plru_touch(plru_q[lk_idx_q], hit_way_c);
  assign plru_wr_base = (hit_upd && lk_idx_q == wr_index_i) ? plru_hit_new : plru_q[wr_index_i];

  // Valid/PLRU update: hit touch, invalidate, write (wins over invalidate), then sweep clear
  always_ff @(posedge clk_i) begin
    if (hit_upd) plru_q[lk_idx_q] <= plru_hit_new;
    if (inv_acc) valid_q[inv_index_i][inv_way_i] <= 1'b0;
    if (wr_acc) begin
      valid_q[wr_index_i][wr_way_i] <= 1'b1;
      plru_q[wr_index_i]            <= plru_touch(plru_wr_base, wr_way_i);
    end
    if (state_q == ST_SWEEP) begin
      valid_q[sweep_idx_q] <= '0;
      plru_q[sweep_idx_q]  <= '0;
    end
  end

endmodule

// File: tb/tb_tag_array_nway.sv
// tb/tb_tag_array_nway.sv - self-checking bench for tag_array_nway (TAG_W=20, IDX_W=4, WAYS=4)
module tb_tag_array_nway;
  localparam int TAG_W = 20;
  localparam int IDX_W = 4;
  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int WW    = 2;

  logic clk = 1'b0;
  logic rst;
  logic lk_valid, wr_en, inv_en, flush_req;
  logic [IDX_W-1:0] lk_index, wr_index, inv_index;
  logic [TAG_W-1:0] lk_tag, wr_tag;
  logic [WW-1:0] wr_way, inv_way;
  logic ready, rsp_valid, rsp_hit;
  logic [WAYS-1:0] rsp_way;
  logic [WW-1:0] rsp_victim;

  int n_tests = 0;
  int n_fail  = 0;

  tag_array_nway #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
    .clk_i(clk), .rst_i(rst),
    .lk_valid_i(lk_valid), .lk_index_i(lk_index), .lk_tag_i(lk_tag),
    .ready_o(ready), .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit),
    .rsp_way_o(rsp_way), .rsp_victim_o(rsp_victim),
    .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_way_i(wr_way), .wr_tag_i(wr_tag),
    .inv_en_i(inv_en), .inv_index_i(inv_index), .inv_way_i(inv_way),
    .flush_req_i(flush_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  bit               m_val [SETS][WAYS];
  bit               m_plru[SETS][WAYS-1];
  int               m_cnt;
  bit               chk_en = 1'b0;
  bit               e_valid, e_hit;
  logic [WAYS-1:0]  e_way;
  logic [WW-1:0]    e_vict;
  int               e_set, e_hitway;
  bit               vv[WAYS];
  logic [TAG_W-1:0] tt[WAYS];
  int               nm, hw, vic;
  bit               nv;

  // Tree level l, node prefix p lives at (1<<l)-1+p; bit 1 = LRU side is the right half.
  task automatic m_touch(input int s, input int w);
    for (int l = 0; l < WW; l++)
      m_plru[s][(1 << l) - 1 + (w >> (WW - l))] = ((w >> (WW - 1 - l)) & 1) == 0;
  endtask

  function automatic int m_plru_way(input int s);
    int p;
    p = 0;
    for (int l = 0; l < WW; l++) p = 2 * p + int'(m_plru[s][(1 << l) - 1 + p]);
    return p;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      m_cnt = SETS; e_valid = 0; e_hit = 0; e_way = '0; e_vict = '0;
      chk_en = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt--;
      e_valid = 0;
    end else begin
      nv = 0;
      if (lk_valid) begin
        for (int w = 0; w < WAYS; w++) begin
          vv[w] = m_val[lk_index][w];
          tt[w] = m_tag[lk_index][w];
        end
`ifdef TAG_ARRAY_BYPASS_EN
        if (inv_en && inv_index == lk_index) vv[inv_way] = 1'b0;
        if (wr_en && wr_index == lk_index) begin
          vv[wr_way] = 1'b1;
          tt[wr_way] = wr_tag;
        end
`endif
        nm = 0; hw = 0;
        for (int w = 0; w < WAYS; w++)
          if (vv[w] && tt[w] == lk_tag) begin nm++; hw = w; end
        vic = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!vv[w]) vic = w;
        if (vic < 0) vic = m_plru_way(int'(lk_index));
        nv = 1;
      end
      if (e_valid && e_hit) m_touch(e_set, e_hitway);
      if (inv_en) m_val[inv_index][inv_way] = 1'b0;
      if (wr_en) begin
        m_tag[wr_index][wr_way] = wr_tag;
        m_val[wr_index][wr_way] = 1'b1;
        m_touch(int'(wr_index), int'(wr_way));
      end
      if (flush_req) begin
        m_clear();
        m_cnt = SETS;
      end
      e_valid = nv;
      if (nv) begin
        e_hit    = nm > 0;
        e_way    = (nm > 0) ? WAYS'(1 << hw) : '0;
        e_vict   = WW'(vic);
        e_set    = int'(lk_index);
        e_hitway = hw;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(m_cnt == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
      chk("rsp_way", 32'(rsp_way), 32'(e_way));
      chk("rsp_victim", 32'(rsp_victim), 32'(e_vict));
      if (rsp_valid) chk("one_hot_match", 32'($countones(rsp_way) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic lookup(input int idx, input logic [TAG_W-1:0] tag);
    lk_valid = 1; lk_index = IDX_W'(idx); lk_tag = tag;
    @(negedge clk);
    lk_valid = 0;
  endtask

  task automatic wr(input int idx, input int way, input logic [TAG_W-1:0] tag);
    wr_en = 1; wr_index = IDX_W'(idx); wr_way = WW'(way); wr_tag = tag;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  int c;

  initial begin
    rst = 1; lk_valid = 0; wr_en = 0; inv_en = 0; flush_req = 0;
    lk_index = '0; wr_index = '0; inv_index = '0; lk_tag = '0; wr_tag = '0;
    wr_way = '0; inv_way = '0;
    @(negedge clk);
    rst = 0;
    // 1: reset latency and cold miss
    wait_ready(c);
    chk("reset_latency", 32'(c), 32'd16);
    lookup(3, 20'h12345);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_hit", 32'(rsp_hit), 32'd0);
    chk("t1_victim", 32'(rsp_victim), 32'd0);
    // 2: write then hit
    wr(5, 2, 20'hABCDE);
    lookup(5, 20'hABCDE);
    chk("t2_hit", 32'(rsp_hit), 32'd1);
    chk("t2_way", 32'(rsp_way), 32'b0100);
    // 3: PLRU victim after filling and hitting way 0
    for (int w = 0; w < WAYS; w++) wr(7, w, 20'h70000 + 20'(w));
    lookup(7, 20'h70000);
    chk("t3_hit_way", 32'(rsp_way), 32'b0001);
    @(negedge clk);
    lookup(7, 20'h7FFFF);
    chk("t3_victim", 32'(rsp_victim), 32'd2);
    lookup(7, 20'h7FFFE);
    chk("t3_victim_again", 32'(rsp_victim), 32'd2);
    // 4: same-cycle write and lookup
    wr_en = 1; wr_index = 4'd9; wr_way = 2'd0; wr_tag = 20'h99999;
    lookup(9, 20'h99999);
    wr_en = 0;
`ifdef TAG_ARRAY_BYPASS_EN
    chk("t4_same_cycle_hit", 32'(rsp_hit), 32'd1);
`else
    chk("t4_same_cycle_hit", 32'(rsp_hit), 32'd0);
`endif
    lookup(9, 20'h99999);
    chk("t4_later_hit", 32'(rsp_hit), 32'd1);
    // write and invalidate of the same entry: write wins
    inv_en = 1; inv_index = 4'd10; inv_way = 2'd1;
    wr(10, 1, 20'hA1A1A);
    inv_en = 0;
    lookup(10, 20'hA1A1A);
    chk("wr_inv_way", 32'(rsp_way), 32'b0010);
    // hit touch and write on the same set in one cycle: write ends up MRU
    for (int w = 0; w < WAYS; w++) wr(11, w, 20'hB0000 + 20'(w));
    lookup(11, 20'hB0001);
    chk("hw_hit_way", 32'(rsp_way), 32'b0010);
    wr(11, 3, 20'hB0033);
    lookup(11, 20'hBFFFF);
    chk("hw_victim", 32'(rsp_victim), 32'd0);
    lookup(11, 20'hB0033);
    chk("hw_new_tag_way", 32'(rsp_way), 32'b1000);
    // 5: invalidate then miss
    inv_en = 1; inv_index = 4'd5; inv_way = 2'd2;
    @(negedge clk);
    inv_en = 0;
    lookup(5, 20'hABCDE);
    chk("t5_hit", 32'(rsp_hit), 32'd0);
    chk("t5_victim", 32'(rsp_victim), 32'd0);
    // flush held during the sweep must not restart it
    flush_req = 1;
    @(negedge clk);
    chk("flush_ready_low", 32'(ready), 32'd0);
    c = 0;
    while (!ready && c < 100) begin
      c++;
      if (c == 4) flush_req = 0;
      @(negedge clk);
    end
    flush_req = 0;
    chk("flush_latency", 32'(c), 32'd16);
    // 6: flush, requests ignored while sweeping, reset at sweep cycle 8
    wr(12, 0, 20'hC0000);
    flush_req = 1;
    @(negedge clk);
    flush_req = 0;
    lk_valid = 1; lk_index = 4'd12; lk_tag = 20'hC0000;
    wr_en = 1; wr_index = 4'd0; wr_way = 2'd0; wr_tag = 20'h0F0F0;
    repeat (7) @(negedge clk);
    lk_valid = 0; wr_en = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    wait_ready(c);
    chk("t6_restart_latency", 32'(c), 32'd16);
    lookup(7, 20'h70000);
    chk("t6_miss7", 32'(rsp_hit), 32'd0);
    lookup(9, 20'h99999);
    chk("t6_miss9", 32'(rsp_hit), 32'd0);
    lookup(12, 20'hC0000);
    chk("t6_miss12", 32'(rsp_hit), 32'd0);
    lookup(0, 20'h0F0F0);
    chk("t6_miss0", 32'(rsp_hit), 32'd0);
    chk("t6_victim0", 32'(rsp_victim), 32'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
